// File: rtl/rv32i_mmio_bus_if.sv
// Core memory port plus RAM-side signals of the RV32I MMIO bus.
// Latency: none, wires only; the bus module defines the timing.
// Backpressure: none, the core bus has no stall, one access per cycle.
interface rv32i_mmio_bus_if;
  logic [31:0] core_addr;
  logic [31:0] core_wr_data;
  logic        core_wr_ena;
  logic [31:0] core_rd_data;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_ena;
  logic [31:0] ram_rd_data;

  // Core/RAM environment side.
  modport master (
    output core_addr, core_wr_data, core_wr_ena, ram_rd_data,
    input  core_rd_data, ram_addr, ram_wr_data, ram_wr_ena
  );

  // Bus decoder side.
  modport slave (
    input  core_addr, core_wr_data, core_wr_ena, ram_rd_data,
    output core_rd_data, ram_addr, ram_wr_data, ram_wr_ena
  );
endinterface

// File: rtl/rv32i_mmio_bus.sv
// RV32I memory-port decoder: RAM passthrough plus LED/button/console-FIFO/timer MMIO.
// Latency: read data 1 cycle after the address for both regions; writes land at the strobe edge.
// Backpressure: none to the core; a console push into a full FIFO is dropped and flagged.
// Optional timer (TIMER_CNT/TIMER_CMP, STATUS.timer_match, timer_irq) built when MMIO_TIMER_EN is defined.
module rv32i_mmio_bus #(
  parameter logic [3:0] MMIO_BASE = 4'hF,
  parameter int         N_LEDS    = 8,
  parameter int         N_BUTTONS = 4,
  parameter int         TX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_mmio_bus_if.slave      bus,
  output logic [N_LEDS-1:0]    leds,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 timer_irq
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(TX_DEPTH + 1);

  localparam logic [5:0] OFF_LEDS = 6'h00;
  localparam logic [5:0] OFF_BTN  = 6'h01;
  localparam logic [5:0] OFF_TX   = 6'h02;
  localparam logic [5:0] OFF_STAT = 6'h03;
  localparam logic [5:0] OFF_CNT  = 6'h04;
  localparam logic [5:0] OFF_CMP  = 6'h05;

  logic                 mmio_sel, mmio_wr, stat_wr, tx_push, push_ok, pop, full, empty;
  logic [5:0]           offset;
  logic [31:0]          wdata, mmio_rd;
  logic                 timer_match, ovf_set;

  logic [N_LEDS-1:0]    leds_q, leds_d;
  logic [N_BUTTONS-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic                 sel_q, sel_d;
  logic [31:0]          rd_q, rd_d;
  logic [7:0]           mem_q [TX_DEPTH];
  logic [7:0]           mem_d [TX_DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;

  // Address bits outside the decode fields and upper store bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{bus.core_addr[27:8], bus.core_addr[1:0], bus.core_wr_data};

  assign mmio_sel = (bus.core_addr[31:28] == MMIO_BASE);
  assign offset   = bus.core_addr[7:2];
  assign wdata    = bus.core_wr_data;
  assign mmio_wr  = bus.core_wr_ena & mmio_sel;
  assign stat_wr  = mmio_wr & (offset == OFF_STAT);
  assign tx_push  = mmio_wr & (offset == OFF_TX);

  assign bus.ram_addr    = bus.core_addr;
  assign bus.ram_wr_data = bus.core_wr_data;
  assign bus.ram_wr_ena  = bus.core_wr_ena & ~mmio_sel;

  assign full     = (count_q == CW'(TX_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = ~empty & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok  = tx_push & (~full | pop);
  assign ovf_set  = tx_push & full & ~pop;
  assign tx_valid = ~empty;
  assign tx_data  = mem_q[rptr_q];
  assign leds     = leds_q;

`ifdef MMIO_TIMER_EN
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        match_q, match_d;

  // Timer: a CNT load beats the increment; the sticky match flag's set beats its W1C clear.
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (mmio_wr && offset == OFF_CNT) cnt_d = wdata;
    if (mmio_wr && offset == OFF_CMP) cmp_d = wdata;
    if (cnt_q == cmp_q)             match_d = 1'b1;
    else if (stat_wr && wdata[3])   match_d = 1'b0;
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign timer_match = match_q;
`else
  assign timer_match = 1'b0;
`endif

  assign timer_irq = timer_match;

  // MMIO read value from the current register state, captured at the edge.
  always_comb begin
    mmio_rd = '0;
    case (offset)
      OFF_LEDS: mmio_rd[N_LEDS-1:0]    = leds_q;
      OFF_BTN:  mmio_rd[N_BUTTONS-1:0] = btn_sync_q;
      OFF_STAT: mmio_rd[3:0]           = {timer_match, ovf_q, empty, full};
`ifdef MMIO_TIMER_EN
      OFF_CNT:  mmio_rd                = cnt_q;
      OFF_CMP:  mmio_rd                = cmp_q;
`endif
      default:  mmio_rd                = '0;
    endcase
  end

  // Next state for LEDs, button synchroniser, read pipe, console FIFO and overflow flag.
  always_comb begin
    leds_d     = leds_q;
    btn_meta_d = buttons;
    btn_sync_d = btn_meta_q;
    sel_d      = mmio_sel;
    rd_d       = mmio_rd;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (mmio_wr && offset == OFF_LEDS) leds_d = wdata[N_LEDS-1:0];
    if (push_ok) begin
      mem_d[wptr_q] = wdata[7:0];
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (ovf_set)                ovf_d = 1'b1;
    else if (stat_wr && wdata[2]) ovf_d = 1'b0;
  end

  // State registers; sel_q resets to MMIO with rd_q=0 so core_rd_data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q     <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sel_q      <= 1'b1;
      rd_q       <= '0;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      leds_q     <= leds_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.core_rd_data = sel_q ? rd_q : bus.ram_rd_data;
endmodule

// File: tb/tb_rv32i_mmio_bus.sv
// Randomised bench for rv32i_mmio_bus against a queue-based reference model.
// Timing: inputs driven at negedge, outputs checked #1 after negedge and #1 after posedge.
// The RAM returns fresh random data every cycle, standing in for its 1-cycle latency.
`timescale 1ns/1ps
module tb_rv32i_mmio_bus;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] leds;
  logic [3:0] buttons = 4'h0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       timer_irq;

  rv32i_mmio_bus_if bus();

  rv32i_mmio_bus dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .leds      (leds),
    .buttons   (buttons),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: register values, FIFO as a byte queue, button sample history.
  logic [7:0]  m_leds;
  logic [7:0]  m_fifo [$];
  logic        m_ovf, m_match;
  logic [31:0] m_cnt, m_cmp;
  logic [3:0]  m_btn_seen [2];   // [0]: sampled last edge, [1]: two edges ago

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a[7:2])
      6'd0: v = {24'h0, m_leds};
      6'd1: v = {28'h0, m_btn_seen[1]};
      6'd3: v = {28'h0, m_match, m_ovf, (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
`ifdef MMIO_TIMER_EN
      6'd4: v = m_cnt;
      6'd5: v = m_cmp;
`endif
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic m_reset();
    m_leds  = 8'h0;
    m_fifo.delete();
    m_ovf   = 1'b0;
    m_match = 1'b0;
    m_cnt   = 32'h0;
    m_cmp   = 32'h0;
    m_btn_seen[0] = 4'h0;
    m_btn_seen[1] = 4'h0;
  endtask

  // One bus cycle; called at a negedge, returns at the next negedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
    logic [31:0] exp_rd;
    logic        is_mmio, was_full, do_pop, ovf_set, match_set, stat_wr;
    logic [5:0]  off;
    bus.core_addr    = a;
    bus.core_wr_data = wd;
    bus.core_wr_ena  = we;
    tx_ready         = rdy;
    #1;
    is_mmio = (a[31:28] == 4'hF);
    off     = a[7:2];
    chk("ram_wr_ena", 32'(bus.ram_wr_ena), 32'(we & ~is_mmio));
    chk("ram_addr", bus.ram_addr, a);
    chk("ram_wr_data", bus.ram_wr_data, wd);
    exp_rd = m_read(a);
    @(posedge clk);
    bus.ram_rd_data = $urandom;
    // model update from pre-edge state
    was_full  = (m_fifo.size() == DEPTH);
    do_pop    = (m_fifo.size() > 0) && rdy;
    ovf_set   = 1'b0;
    match_set = (m_cnt == m_cmp);
    stat_wr   = we && is_mmio && off == 6'd3;
    if (do_pop) void'(m_fifo.pop_front());
    if (we && is_mmio && off == 6'd2) begin
      if (was_full && !do_pop) ovf_set = 1'b1;
      else m_fifo.push_back(wd[7:0]);
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (stat_wr && wd[2]) m_ovf = 1'b0;
`ifdef MMIO_TIMER_EN
    if (match_set) m_match = 1'b1;
    else if (stat_wr && wd[3]) m_match = 1'b0;
    m_cnt = (we && is_mmio && off == 6'd4) ? wd : m_cnt + 32'd1;
    if (we && is_mmio && off == 6'd5) m_cmp = wd;
`endif
    if (we && is_mmio && off == 6'd0) m_leds = wd[7:0];
    m_btn_seen[1] = m_btn_seen[0];
    m_btn_seen[0] = buttons;
    #1;
    chk("core_rd_data", bus.core_rd_data, is_mmio ? exp_rd : bus.ram_rd_data);
    chk("leds", 32'(leds), 32'(m_leds));
    chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_fifo[0]));
    chk("timer_irq", 32'(timer_irq), 32'(m_match));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; called and returns at a negedge.
  task automatic do_reset();
    bus.core_wr_ena = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_timer_irq", 32'(timer_irq), 32'h0);
    chk("rst_core_rd_data", bus.core_rd_data, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0]  a, wd;
  logic         we, rdy;
  int unsigned  pick;
  logic [5:0]   off;
  int           k;

  initial begin
    bus.core_addr    = 32'h0;
    bus.core_wr_data = 32'h0;
    bus.core_wr_ena  = 1'b0;
    bus.ram_rd_data  = 32'h0;
    m_reset();
    @(negedge clk);
    do_reset();

    // RAM read/write passthrough
    cycle(32'h0000_0100, 32'h0, 1'b0, 1'b0);
    bus.ram_rd_data = 32'hDEAD_BEEF;
    #1 chk("ram_read", bus.core_rd_data, 32'hDEAD_BEEF);
    cycle(32'h0000_0100, 32'h1234_5678, 1'b1, 1'b0);
    cycle(32'h0000_0100, 32'h0, 1'b0, 1'b0);

    // LED register
    cycle(32'hF000_0000, 32'h0000_00A5, 1'b1, 1'b0);
    chk("leds_a5", 32'(leds), 32'hA5);
    cycle(32'hF000_0000, 32'h0, 1'b0, 1'b0);
    chk("leds_read", bus.core_rd_data, 32'hA5);

    // FIFO overfill then drain
    for (int i = 0; i < 5; i++) cycle(32'hF000_0008, 32'h41 + i, 1'b1, 1'b0);
    cycle(32'hF000_000C, 32'h0, 1'b0, 1'b0);
    chk("status_full_ovf", bus.core_rd_data & 32'h7, 32'h5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(tx_data), 32'h41 + i);
      cycle(32'h0000_0100, 32'h0, 1'b0, 1'b1);
    end
    chk("drained_valid", 32'(tx_valid), 32'h0);

    // Push+pop while full, then overflow and W1C
    cycle(32'hF000_000C, 32'h4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(32'hF000_0008, 32'h61 + i, 1'b1, 1'b0);
    cycle(32'hF000_0008, 32'h55, 1'b1, 1'b1);
    cycle(32'hF000_000C, 32'h0, 1'b0, 1'b0);
    chk("pushpop_full", bus.core_rd_data & 32'h7, 32'h1);
    cycle(32'hF000_0008, 32'h66, 1'b1, 1'b0);
    cycle(32'hF000_000C, 32'h0, 1'b0, 1'b0);
    chk("overflow_set", bus.core_rd_data & 32'h7, 32'h5);
    cycle(32'hF000_000C, 32'h4, 1'b1, 1'b0);
    cycle(32'hF000_000C, 32'h0, 1'b0, 1'b0);
    chk("overflow_clr", bus.core_rd_data & 32'h7, 32'h1);
    for (int i = 0; i < 4; i++) cycle(32'h0000_0200, 32'h0, 1'b0, 1'b1);

`ifdef MMIO_TIMER_EN
    // Timer match latency and W1C
    do_reset();
    cycle(32'hF000_0014, 32'd10, 1'b1, 1'b0);
    cycle(32'hF000_000C, 32'h8, 1'b1, 1'b0);
    cycle(32'hF000_0010, 32'd0, 1'b1, 1'b0);
    k = 0;
    while (!timer_irq && k < 40) begin
      cycle(32'h0000_0100, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk("irq_latency", 32'(k), 32'd11);
    cycle(32'hF000_000C, 32'h8, 1'b1, 1'b0);
    chk("irq_cleared", 32'(timer_irq), 32'h0);
`endif

    // Button synchroniser
    buttons = 4'b0101;
    for (int i = 0; i < 3; i++) cycle(32'hF000_0004, 32'h0, 1'b0, 1'b0);
    chk("buttons_sync", bus.core_rd_data, 32'h5);

    // Reset mid-drain
    cycle(32'hF000_0000, 32'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(32'hF000_0008, 32'h70 + i, 1'b1, 1'b0);
    cycle(32'h0000_0100, 32'h0, 1'b0, 1'b1);
    do_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 3) begin
        a = {4'($urandom_range(0, 14)), 28'($urandom)};
      end else begin
        off = (pick == 9) ? 6'($urandom_range(0, 63)) : 6'(pick - 3);
        a = {4'hF, 20'($urandom), off, 2'($urandom)};
      end
      wd  = $urandom;
      we  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) buttons = 4'($urandom);
      cycle(a, wd, we, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
